rv32i_imem_linebuf: RTL and testbench
=====================================

Name: rv32i_imem_linebuf

Overview:
Instruction-memory responder for the fetch stage. It answers the fetch PC (PCF) with an instruction (InstrF) from a single-line buffer. On a miss it stalls fetch and refills the line from a backing memory using a request/acknowledge handshake followed by a burst of read beats. ImemStallF is ORed into the hazard unit's StallF/StallD logic.

Parameters:
LINE_WORDS, 4, words per line; power of 2, >=2
NOP_INSTR, 32'h00000013, value driven on InstrF while missing (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
PCF  input  32  fetch PC; PCF[1:0] ignored
InvalidateF  input  1  fence.i; invalidate buffered line
InstrF  output  32  instruction for PCF, combinational from buffer
ImemStallF  output  1  high while PCF misses or fill in progress
mem_req  output  1  line-fill request, held until mem_ack
mem_addr  output  32  line base address (low log2(LINE_WORDS)+2 bits zero)
mem_ack  input  1  backing memory accepts request
mem_rvalid  input  1  read beat valid
mem_rdata  input  32  read beat data; beats arrive in ascending word order

Behaviour:
- Storage: valid bit, tag = PCF[31:log2(LINE_WORDS)+2], LINE_WORDS x 32 data words; word index = PCF[log2(LINE_WORDS)+1:2].
- hit = valid && tag==PCF tag && state==IDLE.
- Hit: InstrF = data[index], same cycle (zero latency). ImemStallF=0.
- Not hit: InstrF=NOP_INSTR and ImemStallF=1, combinationally.
- FSM IDLE->REQ: on the rising edge of a non-hit cycle. Latch mem_addr = line base of PCF.
- REQ: mem_req=1, mem_addr stable. Go to FILL on the edge where mem_ack=1.
- FILL: mem_req=0. Each mem_rvalid beat writes data[beat_cnt] and increments beat_cnt (log2(LINE_WORDS) bits, cleared on entry).
- On the last beat (beat_cnt==LINE_WORDS-1): set tag from the latched address, set valid = !inv_pend, clear inv_pend, go to IDLE.
- First hit is possible in the cycle after the last beat.
- mem_rvalid in IDLE or REQ is ignored.
- Minimum miss penalty: 1 (IDLE->REQ) + ack wait + LINE_WORDS beats.
- A fill always completes once started. A PCF change during REQ/FILL does not abort it; PCF is re-compared in IDLE.
- InvalidateF in IDLE: valid<=0 next edge. It has priority over a hit in that cycle for the next edge only; the current cycle still returns buffered data.
- InvalidateF in REQ/FILL: sets inv_pend; the completed line is written with valid=0.
- Reset values: state=IDLE, valid=0, inv_pend=0, beat_cnt=0, mem_req=0, mem_addr=0. Consequently InstrF=NOP_INSTR and ImemStallF=1 while in reset.
- Reset mid-fill abandons the fill immediately. The backing memory must discard in-flight beats on reset.

Optional Feature:
Macro IMEM_PERF_CNT_EN.
- Defined: adds output ports hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
- hit_cnt increments on each edge where hit=1.
- miss_cnt increments on each IDLE->REQ transition.
- Both saturate at 32'hFFFFFFFF.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package rv32i_pkg holds NOP_INSTR constant and state encoding (IDLE=2'd0, REQ=2'd1, FILL=2'd2).
- One natural sub-module: rv32i_line_store, containing the data array, write port (index, data, we) and read mux (index -> word). The FSM, tag/valid and counters stay in the top module.

Test Plan:
- Reset, then PCF=0x100, ack after 2 cycles, beats 0x11,0x22,0x33,0x44 -> mem_addr=0x100, mem_req high 2 cycles, ImemStallF high through last beat, then InstrF=0x11, ImemStallF=0.
- After fill, PCF=0x104/0x108/0x10C on consecutive cycles -> InstrF=0x22/0x33/0x44, ImemStallF=0, no mem_req.
- PCF=0x110 after line 0x100 valid -> miss, mem_addr=0x110, refill; then PCF=0x100 misses again (single line).
- InvalidateF pulsed mid-FILL for 0x200 -> fill completes, ImemStallF stays 1, a second request to 0x200 is issued.
- rst low during FILL beat 2, released -> mem_req=0, InstrF=0x00000013, ImemStallF=1, new request for current PCF.
- With IMEM_PERF_CNT_EN, 1 miss then 3 hits -> miss_cnt=1, hit_cnt=3.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared constants and FSM encoding for the fetch-side instruction line buffer.
package rv32i_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StFill = 2'd2
    } imem_state_e;

endpackage

// File: rtl/rv32i_line_store.sv
// Data array for one buffered instruction line: a single write port and a
// combinational read mux.
module rv32i_line_store
    import rv32i_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [$clog2(LINE_WORDS)-1:0] i_wr_idx,
    input  logic [31:0]                   i_wr_data,
    input  logic [$clog2(LINE_WORDS)-1:0] i_rd_idx,
    output logic [31:0]                   o_rd_data
);

    logic [31:0] r_data [LINE_WORDS];

    // Contents are qualified by the valid bit in the top, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/rv32i_imem_linebuf.sv
// Single-line instruction buffer for the fetch stage; stalls fetch and refills
// the line from backing memory on a miss. IMEM_PERF_CNT_EN adds hit/miss counters.
module rv32i_imem_linebuf
    import rv32i_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [31:0] NOP_INSTR  = rv32i_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        InvalidateF,
    output logic [31:0] InstrF,
    output logic        ImemStallF,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef IMEM_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    imem_state_e        r_state;
    logic               r_valid;
    logic [31:OFF_W]    r_tag;
    logic               r_inv_pend;
    logic [IDX_W-1:0]   r_beat_cnt;
    logic               r_mem_req;
    logic [31:0]        r_mem_addr;

    logic               w_hit;
    logic               w_we;
    logic [31:0]        w_rd_word;

    assign w_hit = r_valid && (r_tag == PCF[31:OFF_W]) && (r_state == StIdle);
    assign w_we  = (r_state == StFill) && mem_rvalid;

    rv32i_line_store #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_store (
        .i_clk     (clk),
        .i_we      (w_we),
        .i_wr_idx  (r_beat_cnt),
        .i_wr_data (mem_rdata),
        .i_rd_idx  (PCF[OFF_W-1:2]),
        .o_rd_data (w_rd_word)
    );

    assign InstrF     = w_hit ? w_rd_word : NOP_INSTR;
    assign ImemStallF = !w_hit;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_valid    <= 1'b0;
            r_tag      <= '0;
            r_inv_pend <= 1'b0;
            r_beat_cnt <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (InvalidateF) begin
                        r_valid <= 1'b0;
                    end
                    if (!w_hit) begin
                        r_state    <= StReq;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {PCF[31:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                StReq: begin
                    if (InvalidateF) begin
                        r_inv_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_state    <= StFill;
                        r_mem_req  <= 1'b0;
                        r_beat_cnt <= '0;
                    end
                end
                StFill: begin
                    if (InvalidateF) begin
                        r_inv_pend <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == LAST_BEAT) begin
                            // A fence.i landing on the last beat also kills the new line.
                            r_tag      <= r_mem_addr[31:OFF_W];
                            r_valid    <= !(r_inv_pend || InvalidateF);
                            r_inv_pend <= 1'b0;
                            r_state    <= StIdle;
                        end
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if ((r_state == StIdle) && !w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`else
`endif

endmodule

// File: tb/tb_rv32i_imem_linebuf.sv
// Scoreboard bench for rv32i_imem_linebuf: expected instructions and fill
// addresses are queued by the stimulus and popped by an independent monitor.
module tb_rv32i_imem_linebuf;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] PCF;
    logic        InvalidateF;
    logic [31:0] InstrF;
    logic        ImemStallF;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef IMEM_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    rv32i_imem_linebuf #(
        .LINE_WORDS (4),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCF         (PCF),
        .InvalidateF (InvalidateF),
        .InstrF      (InstrF),
        .ImemStallF  (ImemStallF),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
`ifdef IMEM_PERF_CNT_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_instr [$];
    logic [31:0] exp_addr  [$];

    logic [31:0] line_a [4];
    logic [31:0] line_b [4];
    logic [31:0] line_c [4];
    logic [31:0] line_d [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops an expected word for every non-stalled cycle and an
    // expected address for every new fill request.
    logic prev_req;
    initial begin
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_req = 1'b0;
            end else begin
                if (!ImemStallF) begin
                    if (exp_instr.size() == 0) begin
                        chk("unexpected_hit", InstrF, NOP);
                        chk("unexpected_hit_stall", {31'd0, ImemStallF}, 32'd1);
                    end else begin
                        chk("hit_instr", InstrF, exp_instr.pop_front());
                    end
                end
                if (mem_req && !prev_req) begin
                    if (exp_addr.size() == 0) begin
                        chk("unexpected_req", {31'd0, mem_req}, 32'd0);
                    end else begin
                        chk("req_addr", mem_addr, exp_addr.pop_front());
                    end
                end
                prev_req = mem_req;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Serves one fill: waits for the request, acks after ack_wait cycles, then
    // streams four beats. Optionally pulses InvalidateF or asserts reset on a beat.
    task automatic fill(input int ack_wait, input logic [31:0] w [4],
                        input int inv_beat, input int abort_beat);
        int waited;
        int req_cycles;
        waited = 0;
        while (!mem_req && waited < 20) begin
            cyc();
            waited++;
        end
        if (!mem_req) begin
            chk("req_timeout", {31'd0, mem_req}, 32'd1);
            return;
        end
        req_cycles = 0;
        for (int c = 0; c < ack_wait; c++) begin
            mem_ack    = (c == ack_wait - 1);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_0000 + c;
            if (mem_req) req_cycles++;
            cyc();
        end
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        chk("req_cycles", req_cycles, ack_wait);
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        for (int b = 0; b < 4; b++) begin
            if (b == abort_beat) begin
                rst = 1'b0;
                #1;
                chk("abort_req", {31'd0, mem_req}, 32'd0);
                chk("abort_instr", InstrF, NOP);
                chk("abort_stall", {31'd0, ImemStallF}, 32'd1);
                chk("abort_addr", mem_addr, 32'd0);
                cyc();
                rst = 1'b1;
                return;
            end
            InvalidateF = (b == inv_beat);
            mem_rvalid  = 1'b1;
            mem_rdata   = w[b];
            chk("fill_stall", {31'd0, ImemStallF}, 32'd1);
            cyc();
        end
        InvalidateF = 1'b0;
        mem_rvalid  = 1'b0;
    endtask

    initial begin
        line_a = '{32'h11, 32'h22, 32'h33, 32'h44};
        line_b = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        line_c = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        line_d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};

        rst         = 1'b0;
        PCF         = 32'h100;
        InvalidateF = 1'b0;
        mem_ack     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        cyc();
        cyc();
        chk("rst_instr", InstrF, NOP);
        chk("rst_stall", {31'd0, ImemStallF}, 32'd1);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        // Cold miss on 0x100, ack on the second request cycle.
        exp_addr.push_back(32'h100);
        rst = 1'b1;
        fill(2, line_a, -1, -1);
        exp_instr.push_back(32'h11);
        cyc();
        PCF = 32'h104;
        exp_instr.push_back(32'h22);
        chk("hit_no_req", {31'd0, mem_req}, 32'd0);
        cyc();
        PCF = 32'h108;
        exp_instr.push_back(32'h33);
        cyc();
        PCF = 32'h10C;
        exp_instr.push_back(32'h44);
`ifdef IMEM_PERF_CNT_EN
        chk("perf_hit", hit_cnt, 32'd3);
        chk("perf_miss", miss_cnt, 32'd1);
`endif
        cyc();
        chk("hits_no_req", {31'd0, mem_req}, 32'd0);

        // Different line evicts 0x100; then 0x100 misses again.
        PCF = 32'h110;
        exp_addr.push_back(32'h110);
        #1;
        chk("miss_stall", {31'd0, ImemStallF}, 32'd1);
        fill(1, line_b, -1, -1);
        exp_instr.push_back(32'hA0);
        cyc();
        PCF = 32'h100;
        exp_addr.push_back(32'h100);
        #1;
        chk("evict_stall", {31'd0, ImemStallF}, 32'd1);
        fill(1, line_a, -1, -1);
        exp_instr.push_back(32'h11);
        cyc();

        // fence.i during the fill: line lands invalid and is requested again.
        PCF = 32'h200;
        exp_addr.push_back(32'h200);
        fill(2, line_c, 1, -1);
        chk("inv_fill_stall", {31'd0, ImemStallF}, 32'd1);
        chk("inv_fill_instr", InstrF, NOP);
        exp_addr.push_back(32'h200);
        fill(1, line_c, -1, -1);
        exp_instr.push_back(32'hB0);

        // fence.i on a hit cycle: this cycle still hits, the next one misses.
        InvalidateF = 1'b1;
        cyc();
        InvalidateF = 1'b0;
        exp_addr.push_back(32'h200);
        #1;
        chk("inv_idle_stall", {31'd0, ImemStallF}, 32'd1);
        fill(1, line_c, -1, -1);
        exp_instr.push_back(32'hB0);
        cyc();

        // Reset on beat 2 abandons the fill; the line is requested again.
        PCF = 32'h300;
        exp_addr.push_back(32'h300);
        fill(2, line_d, -1, 2);
        exp_addr.push_back(32'h300);
        fill(1, line_d, -1, -1);
        exp_instr.push_back(32'hC0);
        cyc();
        PCF = 32'h30C;
        exp_instr.push_back(32'hC3);
        cyc();
        PCF = 32'h400;
        exp_addr.push_back(32'h400);
        cyc();
        cyc();

        chk("instr_queue_drained", exp_instr.size(), 32'd0);
        chk("addr_queue_drained", exp_addr.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
